// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control                                              |
// | Purpose  : Moore control FSM for a multicycle RV32I-subset datapath        |
// |            (lw, sw, add, sub, and, or, addi, beq). Drives all datapath     |
// |            enables, mux selects and the ALU control code, counts retired   |
// |            instructions and halts (or skips) on unsupported encodings.     |
// | Ports    : clk, reset (async, active-low)                                  |
// |            inst [31:0] IR contents, zero ALU zero flag                     |
// |            PCWrite, IorD, memRead, memWrite, IRWrite, MemtoReg, regWrite,  |
// |            ALUSrcA, ALUSrcB[1:0], PCSource, alu_ctrl[3:0]                  |
// |            state[3:0] debug state, halted, instret[31:0]                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        regWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSource,
    output logic [3:0]  alu_ctrl,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;

    state_t      r_state;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_r_legal;
    logic [3:0]  w_r_alu;
    logic        w_retire;
    state_t      w_decode_next;
    logic        w_pc_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_funct7 = inst[31:25];

    // Register and immediate fields belong to the datapath, not the controller.
    logic w_unused_inst_bits;
    assign w_unused_inst_bits = &{1'b0, inst[24:15], inst[11:7]};

    // R-type legality and ALU code share one decode so they cannot disagree.
    always_comb begin
        w_r_legal = 1'b1;
        w_r_alu   = c_alu_add;
        case ({w_funct7, w_funct3})
            {7'b0000000, 3'b000}: w_r_alu = c_alu_add;
            {7'b0100000, 3'b000}: w_r_alu = c_alu_sub;
            {7'b0000000, 3'b111}: w_r_alu = c_alu_and;
            {7'b0000000, 3'b110}: w_r_alu = c_alu_or;
            default: begin
                w_r_legal = 1'b0;
                w_r_alu   = c_alu_add;
            end
        endcase
    end

    always_comb begin
        if (HALT_ON_ILLEGAL) begin
            w_decode_next = S_HALT;
        end else begin
            w_decode_next = S_FETCH;
        end
        case (w_opcode)
            c_op_load, c_op_store: w_decode_next = S_MEM_ADDR;
            c_op_reg:    if (w_r_legal)         w_decode_next = S_R_EXEC;
            c_op_imm:    if (w_funct3 == 3'b000) w_decode_next = S_I_EXEC;
            c_op_branch: if (w_funct3 == 3'b000) w_decode_next = S_BRANCH;
            default: ;
        endcase
    end

    // Every final state of a legal instruction retires it on its exit edge.
    assign w_retire = (r_state == S_MEM_WB) || (r_state == S_MEM_WR) ||
                      (r_state == S_R_WB)   || (r_state == S_I_WB)   ||
                      (r_state == S_BRANCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_instret <= r_instret + {31'd0, w_retire};
            case (r_state)
                S_FETCH:    r_state <= S_DECODE;
                S_DECODE:   r_state <= w_decode_next;
                S_MEM_ADDR: begin
                    if (w_opcode == c_op_store) begin
                        r_state <= S_MEM_WR;
                    end else begin
                        r_state <= S_MEM_RD;
                    end
                end
                S_MEM_RD:   r_state <= S_MEM_WB;
                S_R_EXEC:   r_state <= S_R_WB;
                S_I_EXEC:   r_state <= S_I_WB;
                S_HALT:     r_state <= S_HALT;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        alu_ctrl    = 4'b0000;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = 1'b1;
                ALUSrcB    = 2'b01;
                alu_ctrl   = c_alu_add;
            end
            // PC takes PC+4 from ALUOut while ALUOut captures the branch target.
            S_DECODE: begin
                ALUSrcB    = 2'b10;
                alu_ctrl   = c_alu_add;
                PCSource   = 1'b1;
                w_pc_write = 1'b1;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_ctrl = c_alu_add;
            end
            S_MEM_RD: begin
                IorD       = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEM_WR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA  = 1'b1;
                alu_ctrl = w_r_alu;
            end
            S_R_WB, S_I_WB: begin
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_ctrl   = c_alu_sub;
                PCSource   = 1'b1;
                w_pc_write = zero;
            end
            default: ;
        endcase
    end

    // State resets to FETCH, whose enables would otherwise be live during reset.
    assign PCWrite  = w_pc_write  & reset;
    assign memRead  = w_mem_read  & reset;
    assign memWrite = w_mem_write & reset;
    assign IRWrite  = w_ir_write  & reset;
    assign regWrite = w_reg_write & reset;

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control                                           |
// | Purpose  : Self-checking bench for multicycle_control. Two instances       |
// |            (HALT_ON_ILLEGAL = 1 and 0) share stimulus; a reference model   |
// |            expands each instruction into its expected per-cycle states     |
// |            and control bundles and tracks the retire counters.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = '0;
    logic        zero = 1'b0;

    logic        a_PCWrite, a_IorD, a_memRead, a_memWrite, a_IRWrite, a_MemtoReg;
    logic        a_regWrite, a_ALUSrcA, a_PCSource, a_halted;
    logic [1:0]  a_ALUSrcB;
    logic [3:0]  a_alu_ctrl, a_state;
    logic [31:0] a_instret;
    logic        b_PCWrite, b_IorD, b_memRead, b_memWrite, b_IRWrite, b_MemtoReg;
    logic        b_regWrite, b_ALUSrcA, b_PCSource, b_halted;
    logic [1:0]  b_ALUSrcB;
    logic [3:0]  b_alu_ctrl, b_state;
    logic [31:0] b_instret;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero),
        .PCWrite(a_PCWrite), .IorD(a_IorD), .memRead(a_memRead), .memWrite(a_memWrite),
        .IRWrite(a_IRWrite), .MemtoReg(a_MemtoReg), .regWrite(a_regWrite),
        .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
        .alu_ctrl(a_alu_ctrl), .state(a_state), .halted(a_halted), .instret(a_instret)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero),
        .PCWrite(b_PCWrite), .IorD(b_IorD), .memRead(b_memRead), .memWrite(b_memWrite),
        .IRWrite(b_IRWrite), .MemtoReg(b_MemtoReg), .regWrite(b_regWrite),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
        .alu_ctrl(b_alu_ctrl), .state(b_state), .halted(b_halted), .instret(b_instret)
    );

    always #5 clk = ~clk;

    // Control bundle: {PCWrite, IorD, memRead, memWrite, IRWrite, MemtoReg,
    //                  regWrite, ALUSrcA, ALUSrcB[1:0], PCSource, alu_ctrl[3:0], halted}
    logic [15:0] a_ctl, b_ctl;
    assign a_ctl = {a_PCWrite, a_IorD, a_memRead, a_memWrite, a_IRWrite, a_MemtoReg,
                    a_regWrite, a_ALUSrcA, a_ALUSrcB, a_PCSource, a_alu_ctrl, a_halted};
    assign b_ctl = {b_PCWrite, b_IorD, b_memRead, b_memWrite, b_IRWrite, b_MemtoReg,
                    b_regWrite, b_ALUSrcA, b_ALUSrcB, b_PCSource, b_alu_ctrl, b_halted};
    localparam logic [15:0] c_en_mask = 16'hBA00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  exp_st [2][32];
    logic [15:0] exp_ct [2][32];
    int          exp_len[2];
    bit          exp_ret[2];
    logic [31:0] cnt    [2];

    function automatic logic [15:0] mk(input bit pcw, input bit iord, input bit mr,
                                       input bit mw, input bit irw, input bit m2r,
                                       input bit rw, input bit sa, input bit [1:0] sb,
                                       input bit pcs, input bit [3:0] alu, input bit h);
        return {pcw, iord, mr, mw, irw, m2r, rw, sa, sb, pcs, alu, h};
    endfunction

    function automatic void push(input int d, input logic [3:0] st, input logic [15:0] ct);
        exp_st[d][exp_len[d]] = st;
        exp_ct[d][exp_len[d]] = ct;
        exp_len[d]++;
    endfunction

    function automatic void build(input int d, input logic [31:0] ins, input logic z, input bit hoi);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         kind;   // 0 lw, 1 sw, 2 R, 3 addi, 4 beq, 5 illegal
        logic [3:0] ralu;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ralu = 4'd2;
        kind = 5;
        if (op == 7'h03) kind = 0;
        else if (op == 7'h23) kind = 1;
        else if (op == 7'h13 && f3 == 3'd0) kind = 3;
        else if (op == 7'h63 && f3 == 3'd0) kind = 4;
        else if (op == 7'h33) begin
            if      (f7 == 7'h00 && f3 == 3'd0) begin kind = 2; ralu = 4'd2; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 2; ralu = 4'd6; end
            else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 2; ralu = 4'd0; end
            else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 2; ralu = 4'd1; end
        end
        exp_len[d] = 0;
        exp_ret[d] = (kind != 5);
        push(d, 4'd0, mk(0,0,1,0,1,0,0,0,2'b01,0,4'd2,0));
        push(d, 4'd1, mk(1,0,0,0,0,0,0,0,2'b10,1,4'd2,0));
        case (kind)
            0: begin
                push(d, 4'd2, mk(0,0,0,0,0,0,0,1,2'b10,0,4'd2,0));
                push(d, 4'd3, mk(0,1,1,0,0,0,0,0,2'b00,0,4'd0,0));
                push(d, 4'd4, mk(0,0,0,0,0,1,1,0,2'b00,0,4'd0,0));
            end
            1: begin
                push(d, 4'd2, mk(0,0,0,0,0,0,0,1,2'b10,0,4'd2,0));
                push(d, 4'd5, mk(0,1,0,1,0,0,0,0,2'b00,0,4'd0,0));
            end
            2: begin
                push(d, 4'd6, mk(0,0,0,0,0,0,0,1,2'b00,0,ralu,0));
                push(d, 4'd7, mk(0,0,0,0,0,0,1,0,2'b00,0,4'd0,0));
            end
            3: begin
                push(d, 4'd8, mk(0,0,0,0,0,0,0,1,2'b10,0,4'd2,0));
                push(d, 4'd9, mk(0,0,0,0,0,0,1,0,2'b00,0,4'd0,0));
            end
            4: push(d, 4'd10, mk(z,0,0,0,0,0,0,1,2'b00,1,4'd6,0));
            default: begin
                if (hoi) begin
                    for (int k = 0; k < 20; k++) push(d, 4'd11, mk(0,0,0,0,0,0,0,0,2'b00,0,4'd0,1));
                end else begin
                    push(d, 4'd0, mk(0,0,1,0,1,0,0,0,2'b01,0,4'd2,0));
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31:20], r[19:15], 3'b010, r[11:7], 7'b0000011};
            1: return {r[31:25], r[24:20], r[19:15], 3'b010, r[11:7], 7'b0100011};
            2: return {7'h00, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
            3: return {7'h20, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
            4: return {7'h00, r[24:20], r[19:15], 3'b111, r[11:7], 7'b0110011};
            5: return {7'h00, r[24:20], r[19:15], 3'b110, r[11:7], 7'b0110011};
            6: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
            default: return {r[31:25], r[24:20], r[19:15], 3'b000, r[11:7], 7'b1100011};
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle, checking both instances each cycle.
    task run(input logic [31:0] ins, input logic z, input bit do_force);
        build(0, ins, z, 1'b1);
        build(1, ins, z, 1'b0);
        for (int i = 0; i < exp_len[0]; i++) begin
            @(negedge clk);
            if (i == 0) begin
                inst = ins;
                zero = z;
            end
            if (i == 1 && do_force) begin
                release dut_a.r_instret;
                cnt[0] = 32'hFFFF_FFFF;
            end
            #1;
            check("a_state",   {28'd0, a_state}, {28'd0, exp_st[0][i]});
            check("a_ctl",     {16'd0, a_ctl},   {16'd0, exp_ct[0][i]});
            check("a_instret", a_instret, cnt[0]);
            if (i < exp_len[1]) begin
                check("b_state",   {28'd0, b_state}, {28'd0, exp_st[1][i]});
                check("b_ctl",     {16'd0, b_ctl},   {16'd0, exp_ct[1][i]});
                check("b_instret", b_instret, cnt[1]);
            end
            if (i == 0 && do_force) force dut_a.r_instret = 32'hFFFF_FFFF;
        end
        if (exp_ret[0]) cnt[0] = cnt[0] + 32'd1;
        if (exp_ret[1]) cnt[1] = cnt[1] + 32'd1;
    endtask

    task check_reset();
        check("rst_a_state",   {28'd0, a_state}, 32'd0);
        check("rst_a_halted",  {31'd0, a_halted}, 32'd0);
        check("rst_a_instret", a_instret, 32'd0);
        check("rst_a_enables", {16'd0, a_ctl & c_en_mask}, 32'd0);
        check("rst_b_state",   {28'd0, b_state}, 32'd0);
        check("rst_b_instret", b_instret, 32'd0);
        check("rst_b_enables", {16'd0, b_ctl & c_en_mask}, 32'd0);
        cnt[0] = '0;
        cnt[1] = '0;
    endtask

    // Release just after a rising edge so the following negedge lands in FETCH.
    task release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [31:0] directed [9] = '{32'h0042A303, 32'h0062A223, 32'hFFF28293, 32'h40628333,
                                  32'h0062F333, 32'h0062E333, 32'h00628333, 32'h00028263,
                                  32'h00028263};
    logic        dir_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [31:0] illegal  [5] = '{32'h0000007F, 32'h0062C333, 32'h4062F333,
                                  32'h00129293, 32'h00029263};

    initial begin
        cnt[0] = '0;
        cnt[1] = '0;
        repeat (2) @(negedge clk);
        #1 check_reset();
        release_reset();

        for (int i = 0; i < 9; i++) run(directed[i], dir_zero[i], 1'b0);
        for (int i = 0; i < 40; i++) run(rand_legal(), 1'($urandom_range(0, 1)), 1'b0);

        // Asynchronous reset in the middle of a lw.
        @(negedge clk) inst = 32'h0042A303;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset();
        repeat (2) @(negedge clk);
        release_reset();

        // Counter wrap: preset the counter, then retire one instruction.
        run(rand_legal(), 1'b0, 1'b1);
        run(rand_legal(), 1'b1, 1'b0);

        // Illegal encodings: instance A halts, instance B skips without retiring.
        for (int i = 0; i < 5; i++) begin
            run(rand_legal(), 1'($urandom_range(0, 1)), 1'b0);
            run(illegal[i], 1'b0, 1'b0);
            @(negedge clk);
            #2 reset = 1'b0;
            #1 check_reset();
            release_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
